hwpe_stream_serialize_flat: RTL and testbench
=============================================

Name: hwpe_stream_serialize_flat

Overview:
- Downstream neighbour of the flat-port HWPE-Stream FIFO wrap.
- Consumes wide words from the FIFO pop side and emits them as a stream of narrower beats, LSB lane first.
- Drops byte-lanes that carry no strobe.
- Flat valid/ready/data/strb ports, so it attaches directly to the FIFO wrap's pop_* ports and to Verilator benches.

Parameters:
- IN_WIDTH, 32, input word width in bits; multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width in bits; multiple of 8.
- SKIP_EMPTY, 1, 1 = skip beats whose strobe slice is all zero; 0 = emit every beat.
- Derived: RATIO = IN_WIDTH/OUT_WIDTH (>=2); IDX_W = clog2(RATIO).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  synchronous soft clear, active-high; same effect as rst.
- in_valid  in  1  input word valid (from FIFO pop_valid).
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  IN_WIDTH  input word.
- in_strb  in  IN_WIDTH/8  input byte strobes.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_WIDTH  output beat data.
- out_strb  out  OUT_WIDTH/8  output beat strobes.
- out_last  out  1  beat is the final emitted beat of its word.
- busy  out  1  a word is held (state SHIFT).

Behaviour:
- Registers: word buffer (data+strb), lane index idx[IDX_W-1:0], state {IDLE, SHIFT}.
- Reset/clear, on the cycle rst or clear is sampled high:
  - state<=IDLE, buffer<=0, idx<=0.
  - Next cycle: out_valid=0, out_data=0, out_strb=0, out_last=0, busy=0.
  - in_ready forced 0 combinationally while rst or clear is high.
  - A word held mid-serialization is discarded with no partial output.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept:
    - SKIP_EMPTY=1 and in_strb==0: word dropped, stay IDLE, nothing emitted.
    - Otherwise: capture word, idx<=first emitted lane, go to SHIFT.
    - First emitted lane = lowest lane with nonzero strb slice if SKIP_EMPTY=1, else 0.
- SHIFT:
  - out_valid=1; out_data/out_strb = buffer slice idx, driven from registers only.
  - No combinational path from in_* to out_*.
  - out_last=1 when no later lane will be emitted: (SKIP_EMPTY=0 and idx==RATIO-1) or (SKIP_EMPTY=1 and all strb slices above idx are zero).
  - out_valid & out_ready & !out_last: idx<=next emitted lane (priority-encode upward).
  - out_valid & out_ready & out_last: word complete.
- Zero-bubble rule: in_ready=1 in SHIFT exactly when out_last & out_ready.
  - On simultaneous final-beat handshake and new-word accept: capture the new word and stay in SHIFT (or go to IDLE if the new word is dropped as all-zero).
  - Without a new word: go to IDLE.
- Latency: word accepted at cycle t -> first beat valid at t+1.
- Sustained throughput = number of emitted beats per word, no idle cycles between words.
- AXI-style stability: once out_valid=1, out_data/out_strb/out_last hold until out_ready; out_valid never drops without a handshake except on rst/clear.
- in_ready may depend combinationally on out_ready. in_valid must not depend on in_ready.
- idx never exceeds RATIO-1; no wrap-around inside a word.

Test Plan:
- Defaults, in_data=0xDDCCBBAA, strb=0xF, out_ready=1 -> beats AA,BB,CC,DD at t+1..t+4, out_last only on DD. Second word 0x44332211 accepted at t+4 -> beat 11 at t+5 (no bubble).
- in_data=0x44332211, strb=0b0101 -> beats 11 (last=0), 33 (last=1), 2 cycles total. strb=0b1000 -> single beat 44, last=1.
- strb=0x0 with SKIP_EMPTY=1 -> word accepted, out_valid stays 0, in_ready=1 next cycle, busy never asserts.
- out_ready low 3 cycles while beat BB presented -> out_valid=1, out_data=BB, out_strb=1 held all 3 cycles; CC follows the cycle after out_ready rises.
- clear pulsed after AA,BB emitted -> out_valid=0 and busy=0 next cycle. Next word 0x11223344 strb=0xF -> first beat 44 (lane 0). rst mid-word gives identical results.
- SKIP_EMPTY=0, strb=0x0, data=0x01020304 -> 4 beats 04,03,02,01, each out_strb=0, last on 01.

Source files
------------

// File: rtl/hwpe_stream_serialize_flat.sv
// hwpe_stream_serialize_flat
//   Splits wide words popped from a flat-port HWPE-Stream FIFO into narrower
//   beats, lowest lane first. With SKIP_EMPTY=1, lanes that carry no strobe
//   are not emitted, and a word with no strobe at all is consumed silently.
//
// Ports
//   clk, rst, clear        clock, sync active-high reset, sync soft clear
//   in_valid/in_ready      input word handshake
//   in_data/in_strb        input word and byte strobes
//   out_valid/out_ready    output beat handshake
//   out_data/out_strb      output beat and its byte strobes
//   out_last               final emitted beat of the current word
//   busy                   a word is held and being serialized
//
// States
//   IDLE  | no word held, ready for a new one
//   SHIFT | word held, presenting lane idx_q
module hwpe_stream_serialize_flat #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter bit          SKIP_EMPTY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [IN_WIDTH/8-1:0]  in_strb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [OUT_WIDTH/8-1:0] out_strb,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned IN_SW  = IN_WIDTH / 8;
  localparam int unsigned OUT_SW = OUT_WIDTH / 8;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] data_q, data_d;
  logic [IN_SW-1:0]    strb_q, strb_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [RATIO-1:0] lane_nz_in, lane_nz_q;
  logic [IDX_W-1:0] first_lane, next_lane, next_skip;
  logic             more_above, last_lane;
  logic             accept, drop;

  always_comb begin
    lane_nz_in = '0;
    lane_nz_q  = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      lane_nz_in[i] = |in_strb[i*OUT_SW +: OUT_SW];
      lane_nz_q[i]  = |strb_q[i*OUT_SW +: OUT_SW];
    end
  end

  // Lowest strobed lane of the incoming word (downward scan, last hit wins).
  always_comb begin
    first_lane = '0;
    for (int i = int'(RATIO) - 1; i >= 0; i--) begin
      if (lane_nz_in[i]) first_lane = IDX_W'(i);
    end
    if (!SKIP_EMPTY) first_lane = '0;
  end

  // Lowest strobed lane strictly above idx_q; absence of one marks the last beat.
  always_comb begin
    next_skip  = '0;
    more_above = 1'b0;
    for (int i = int'(RATIO) - 1; i >= 0; i--) begin
      if ((i > int'(idx_q)) && lane_nz_q[i]) begin
        next_skip  = IDX_W'(i);
        more_above = 1'b1;
      end
    end
    if (SKIP_EMPTY) begin
      next_lane = next_skip;
      last_lane = !more_above;
    end else begin
      next_lane = idx_q + IDX_W'(1);
      last_lane = (32'(idx_q) == RATIO - 1);
    end
  end

  // Outputs depend only on held state; gated so IDLE presents all zeros.
  assign busy      = (state_q == SHIFT);
  assign out_valid = busy;
  assign out_data  = busy ? data_q[idx_q*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign out_strb  = busy ? strb_q[idx_q*OUT_SW +: OUT_SW] : '0;
  assign out_last  = busy & last_lane;

  // A new word may enter while the final beat of the current one leaves.
  assign in_ready = !rst && !clear && (!busy || (last_lane && out_ready));
  assign accept   = in_valid & in_ready;
  assign drop     = SKIP_EMPTY && (in_strb == '0);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    strb_d  = strb_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept && !drop) begin
          data_d  = in_data;
          strb_d  = in_strb;
          idx_d   = first_lane;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (!last_lane) begin
            idx_d = next_lane;
          end else if (accept && !drop) begin
            data_d  = in_data;
            strb_d  = in_strb;
            idx_d   = first_lane;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      data_q  <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_serialize_flat.sv
module tb_hwpe_stream_serialize_flat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, in_valid, out_ready;
  logic [31:0] in_data;
  logic [3:0]  in_strb;
  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [0:0]  out_strb;

  logic        clear_b, in_valid_b, out_ready_b;
  logic [31:0] in_data_b;
  logic [3:0]  in_strb_b;
  logic        in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [7:0]  out_data_b;
  logic [0:0]  out_strb_b;

  hwpe_stream_serialize_flat #(.IN_WIDTH(32), .OUT_WIDTH(8), .SKIP_EMPTY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_strb(in_strb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_strb(out_strb), .out_last(out_last), .busy(busy)
  );

  hwpe_stream_serialize_flat #(.IN_WIDTH(32), .OUT_WIDTH(8), .SKIP_EMPTY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_strb(in_strb_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_strb(out_strb_b), .out_last(out_last_b), .busy(busy_b)
  );

  typedef struct {
    logic        rst, clr, iv;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        ordy;
    logic        ird, ov;
    logic [7:0]  od;
    logic        os, ol, bsy;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input int r, input int c, input int iv, input int d, input int s,
                     input int ordy, input int ird, input int ov, input int od,
                     input int os, input int ol, input int b);
    vec_t v;
    v.rst = r[0]; v.clr = c[0]; v.iv = iv[0]; v.data = d; v.strb = s[3:0];
    v.ordy = ordy[0]; v.ird = ird[0]; v.ov = ov[0]; v.od = od[7:0];
    v.os = os[0]; v.ol = ol[0]; v.bsy = b[0];
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  initial begin
    //  rst clr iv data          strb ordy | ird ov od     os ol busy
    add(0, 0, 1, 32'hDDCCBBAA, 4'hF, 1,    1, 0, 8'h00, 0, 0, 0); // 0 accept
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'hAA, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'hBB, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'hCC, 1, 0, 1);
    add(0, 0, 1, 32'h44332211, 4'hF, 1,    1, 1, 8'hDD, 1, 1, 1); // no-bubble accept
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h11, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h22, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h33, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    1, 1, 8'h44, 1, 1, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    1, 0, 8'h00, 0, 0, 0); // 9 idle
    add(0, 0, 1, 32'h44332211, 4'h5, 1,    1, 0, 8'h00, 0, 0, 0); // sparse strb
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h11, 1, 0, 1);
    add(0, 0, 1, 32'h44332211, 4'h8, 1,    1, 1, 8'h33, 1, 1, 1); // top lane only
    add(0, 0, 0, 32'h0,        4'h0, 1,    1, 1, 8'h44, 1, 1, 1);
    add(0, 0, 1, 32'h99999999, 4'h0, 1,    1, 0, 8'h00, 0, 0, 0); // all-zero strb
    add(0, 0, 0, 32'h0,        4'h0, 1,    1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 32'hDDCCBBAA, 4'hF, 1,    1, 0, 8'h00, 0, 0, 0); // 16 stall test
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'hAA, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 0,    0, 1, 8'hBB, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 0,    0, 1, 8'hBB, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 0,    0, 1, 8'hBB, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'hBB, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'hCC, 1, 0, 1);
    add(0, 0, 1, 32'h11223344, 4'hF, 1,    1, 1, 8'hDD, 1, 1, 1); // 23
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h44, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h33, 1, 0, 1);
    add(0, 1, 1, 32'h55555555, 4'hF, 1,    0, 1, 8'h22, 1, 0, 1); // clear mid-word
    add(0, 0, 1, 32'h11223344, 4'hF, 1,    1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h44, 1, 0, 1);
    add(0, 0, 0, 32'h0,        4'h0, 1,    0, 1, 8'h33, 1, 0, 1);
    add(1, 0, 1, 32'h55555555, 4'hF, 1,    0, 1, 8'h22, 1, 0, 1); // rst mid-word
    add(0, 0, 1, 32'h0000AB00, 4'h2, 1,    1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 32'h77777777, 4'h0, 1,    1, 1, 8'hAB, 1, 1, 1); // drop on last beat
    add(0, 0, 0, 32'h0,        4'h0, 1,    1, 0, 8'h00, 0, 0, 0);

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_strb = '0; out_ready = 1'b1;
    clear_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; in_strb_b = '0; out_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", -1, int'(in_ready), 0);
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      rst = tbl[k].rst; clear = tbl[k].clr; in_valid = tbl[k].iv;
      in_data = tbl[k].data; in_strb = tbl[k].strb; out_ready = tbl[k].ordy;
      #1;
      chk("in_ready",  k, int'(in_ready),  int'(tbl[k].ird));
      chk("out_valid", k, int'(out_valid), int'(tbl[k].ov));
      chk("out_data",  k, int'(out_data),  int'(tbl[k].od));
      chk("out_strb",  k, int'(out_strb),  int'(tbl[k].os));
      chk("out_last",  k, int'(out_last),  int'(tbl[k].ol));
      chk("busy",      k, int'(busy),      int'(tbl[k].bsy));
    end

    // SKIP_EMPTY=0: an unstrobed word is still emitted lane by lane.
    begin
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h04; exp_b[1] = 8'h03; exp_b[2] = 8'h02; exp_b[3] = 8'h01;
      @(negedge clk);
      in_valid_b = 1'b1; in_data_b = 32'h01020304; in_strb_b = 4'h0;
      #1;
      chk("b_in_ready_idle", 100, int'(in_ready_b), 1);
      chk("b_out_valid_idle", 100, int'(out_valid_b), 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        in_valid_b = 1'b0;
        #1;
        chk("b_out_valid", 101 + i, int'(out_valid_b), 1);
        chk("b_out_data",  101 + i, int'(out_data_b),  int'(exp_b[i]));
        chk("b_out_strb",  101 + i, int'(out_strb_b),  0);
        chk("b_out_last",  101 + i, int'(out_last_b),  (i == 3) ? 1 : 0);
        chk("b_busy",      101 + i, int'(busy_b),      1);
      end
      @(negedge clk);
      #1;
      chk("b_out_valid_end", 105, int'(out_valid_b), 0);
      chk("b_busy_end",      105, int'(busy_b),      0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
